rv_muldiv_unit: RTL and testbench

- Parametrised multi-cycle M-extension execute unit for the RV32IM pipeline.
- Sits beside the ALU in the EX stage. Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively.
- Holds BUSY so the pipeline registers stall until DONE.
- Generalises the single-cycle ALU path: XLEN and radix (bits retired per cycle) are configurable, and the unit supports flush on branch/jump redirect.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/rv_muldiv_unit_step.sv | 39 +++
 rtl/rv_muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide execute unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rv_muldiv_unit_step.sv
// One iteration of the datapath: BITS_PER_CYCLE shift-add (multiply) or
// restoring trial-subtract (divide) steps on a {hi, lo} accumulator.
module rv_muldiv_unit_step #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                is_div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     operand_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [2*XLEN-1:0] a;
    logic [XLEN:0]     sum;
    logic [2*XLEN:0]   sh;

    always_comb begin
        a   = acc_i;
        sum = '0;
        sh  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_i) begin
                // hi holds the partial remainder, lo the dividend shifting into quotient bits
                sh  = {a, 1'b0};
                sum = sh[2*XLEN:XLEN] - {1'b0, operand_i};
                if (!sum[XLEN]) begin
                    a = {sum[XLEN-1:0], sh[XLEN-1:1], 1'b1};
                end else begin
                    a = sh[2*XLEN-1:0];
                end
            end else begin
                sum = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, operand_i} : '0);
                a   = {sum, a[XLEN-1:1]};
            end
        end
        acc_o = a;
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative M-extension execute unit: sign handling, FSM, iteration counter
// and the final sign-correction / word-select stage.
module rv_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [2*XLEN-1:0]   acc_q, acc_d, acc_step;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic                fast_q, fast_d;

    logic                a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]     mag_a, mag_b, special_res;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem, fix_res;

    assign a_signed = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_MULHSU) ||
                      (FUNCT3 == F3_DIV)  || (FUNCT3 == F3_REM);
    assign b_signed = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
    assign neg_a    = a_signed && OPERAND_A[XLEN-1];
    assign neg_b    = b_signed && OPERAND_B[XLEN-1];
    assign mag_a    = neg_a ? -OPERAND_A : OPERAND_A;
    assign mag_b    = neg_b ? -OPERAND_B : OPERAND_B;
    assign div_zero = FUNCT3[2] && (OPERAND_B == '0);
    assign div_ovf  = ((FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM)) &&
                      (OPERAND_A == MOST_NEG) && (OPERAND_B == '1);
    // FUNCT3[1] separates REM/REMU from DIV/DIVU
    assign special_res = div_zero ? (FUNCT3[1] ? OPERAND_A : '1)
                                  : (FUNCT3[1] ? '0 : OPERAND_A);

    assign prod = neg_quo_q ? -acc_q : acc_q;
    assign quo  = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = acc_q[XLEN-1:0];
        if (!fast_q) begin
            case (f3_q)
                F3_MUL:                       fix_res = prod[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:              fix_res = quo;
                default:                      fix_res = rem;
            endcase
        end
    end

    rv_muldiv_unit_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div_i  (f3_q[2]),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        fast_d    = fast_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (START && !FLUSH) begin
                    f3_d      = FUNCT3;
                    opnd_d    = mag_b;
                    neg_quo_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    cnt_d     = CNT_W'(N);
                    fast_d    = div_zero || div_ovf;
                    if (div_zero || div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, special_res};
                        state_d = ST_FIX;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            f3_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            fast_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            fast_q    <= fast_d;
            result_q  <= result_d;
        end
    end

    assign BUSY   = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign DONE   = (state_q == ST_DONE);
    assign RESULT = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Bench for rv_muldiv_unit: radix-2 and radix-16 instances share stimulus and
// are checked every cycle against an arithmetic reference model.
module tb_rv_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [2:0]  FUNCT3 = '0;
    logic [31:0] OPERAND_A = '0;
    logic [31:0] OPERAND_B = '0;
    logic        FLUSH = 1'b0;
    logic [1:0]  busy_w, done_w;
    logic [31:0] res_w [2];

    int vectors = 0;
    int miscompares = 0;

    int          m_left [2] = '{0, 0};
    logic        m_done [2] = '{1'b0, 1'b0};
    logic [31:0] m_res  [2] = '{32'h0, 32'h0};
    logic [31:0] m_pend [2] = '{32'h0, 32'h0};
    int          nper   [2] = '{32, 8};

    always #5 CLK = ~CLK;

    rv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut_r1 (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3), .OPERAND_A(OPERAND_A),
        .OPERAND_B(OPERAND_B), .FLUSH(FLUSH), .BUSY(busy_w[0]), .DONE(done_w[0]),
        .RESULT(res_w[0])
    );

    rv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut_r4 (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3), .OPERAND_A(OPERAND_A),
        .OPERAND_B(OPERAND_B), .FLUSH(FLUSH), .BUSY(busy_w[1]), .DONE(done_w[1]),
        .RESULT(res_w[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'(b);
        p  = '0;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    // Reference: an accepted op stays busy for N+1 cycles (1 on the fast path),
    // then shows DONE with its result for one cycle.
    initial begin
        forever begin
            @(posedge CLK or negedge RESET);
            for (int k = 0; k < 2; k++) begin
                if (!RESET) begin
                    m_left[k] = 0;
                    m_done[k] = 1'b0;
                    m_res[k]  = '0;
                end else if (m_left[k] > 0) begin
                    if (FLUSH) begin
                        m_left[k] = 0;
                    end else begin
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_done[k] = 1'b1;
                            m_res[k]  = m_pend[k];
                        end
                    end
                end else begin
                    m_done[k] = 1'b0;
                    if (START && !FLUSH) begin
                        m_left[k] = is_fast(FUNCT3, OPERAND_A, OPERAND_B) ? 1 : nper[k] + 1;
                        m_pend[k] = ref_op(FUNCT3, OPERAND_A, OPERAND_B);
                    end
                end
            end
        end
    end

    initial begin
        #20;
        forever begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                chk(k == 0 ? "busy_r1" : "busy_r4", {31'b0, busy_w[k]}, {31'b0, m_left[k] > 0});
                chk(k == 0 ? "done_r1" : "done_r4", {31'b0, done_w[k]}, {31'b0, m_done[k]});
                chk(k == 0 ? "result_r1" : "result_r4", res_w[k], m_res[k]);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy_w != 2'b00; i++) begin
            @(posedge CLK);
            #1;
        end
        chk("idle_timeout", {30'b0, busy_w}, 32'h0);
    endtask

    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat1,
                         input int lat4);
        int          got_lat [2];
        int          busy_cnt [2];
        logic [31:0] got_res [2];
        wait_idle();
        @(posedge CLK);
        #1;
        START = 1'b1; FUNCT3 = f; OPERAND_A = a; OPERAND_B = b;
        got_lat  = '{-1, -1};
        busy_cnt = '{0, 0};
        got_res  = '{32'h0, 32'h0};
        for (int cyc = 1; cyc <= 60 && (got_lat[0] < 0 || got_lat[1] < 0); cyc++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (got_lat[k] < 0 && busy_w[k]) busy_cnt[k]++;
                if (got_lat[k] < 0 && done_w[k]) begin
                    got_lat[k] = cyc;
                    got_res[k] = res_w[k];
                end
            end
        end
        chk({name, "_res_r1"}, got_res[0], exp);
        chk({name, "_res_r4"}, got_res[1], exp);
        chk({name, "_lat_r1"}, got_lat[0], lat1);
        chk({name, "_lat_r4"}, got_lat[1], lat4);
        chk({name, "_busy_r1"}, busy_cnt[0], lat1 - 1);
        chk({name, "_busy_r4"}, busy_cnt[1], lat4 - 1);
    endtask

    initial begin
        bit seen_done;
        int got_lat;
        chk("pin_mul",    ref_op(3'b000, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("pin_mulhsu", ref_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("pin_rem",    ref_op(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_divovf", ref_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        #2 RESET = 1'b0;
        #21 RESET = 1'b1;
        #1;
        chk("reset_busy", {30'b0, busy_w}, 32'h0);
        chk("reset_done", {30'b0, done_w}, 32'h0);
        chk("reset_res", res_w[0], 32'h0);

        do_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 10);
        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 10);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 10);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 10);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 10);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 10);
        do_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34, 10);
        do_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34, 10);
        do_op("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2, 2);
        do_op("remu0",  3'b111, 32'd5,         32'd0,         32'd5,         2, 2);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 2);
        do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2, 2);

        // Flush a long divide after 10 cycles; last result (0) must persist.
        do_op("pre_flush", 3'b001, 32'h0000_0003, 32'h0000_0005, 32'h0, 34, 10);
        @(posedge CLK);
        #1;
        START = 1'b1; FUNCT3 = 3'b101; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        chk("flush_busy", {31'b0, busy_w[0]}, 32'h0);
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done_w[0]) seen_done = 1'b1;
            @(posedge CLK);
            #1;
        end
        chk("flush_no_done", {31'b0, seen_done}, 32'h0);
        chk("flush_result", res_w[0], 32'h0);

        wait_idle();
        @(posedge CLK);
        #1;
        START = 1'b1; FLUSH = 1'b1; FUNCT3 = 3'b000; OPERAND_A = 32'd3; OPERAND_B = 32'd3;
        @(posedge CLK);
        #1;
        START = 1'b0; FLUSH = 1'b0;
        chk("flush_start_busy", {30'b0, busy_w}, 32'h0);

        // Asynchronous reset between edges in the middle of a multiply.
        do_op("pre_reset", 3'b000, 32'd6, 32'd7, 32'd42, 34, 10);
        @(posedge CLK);
        #1;
        START = 1'b1; FUNCT3 = 3'b000; OPERAND_A = 32'd9; OPERAND_B = 32'd9;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        #2 RESET = 1'b0;
        #1;
        chk("arst_busy", {30'b0, busy_w}, 32'h0);
        chk("arst_done", {30'b0, done_w}, 32'h0);
        chk("arst_res_r1", res_w[0], 32'h0);
        chk("arst_res_r4", res_w[1], 32'h0);
        @(posedge CLK);
        #3 RESET = 1'b1;

        // Back-to-back: second START issued during the DONE cycle of the first.
        do_op("b2b_first", 3'b000, 32'd5, 32'd5, 32'd25, 34, 10);
        @(posedge CLK);
        #1;
        START = 1'b1; FUNCT3 = 3'b000; OPERAND_A = 32'd11; OPERAND_B = 32'd3;
        for (int cyc = 0; cyc < 60 && !done_w[0]; cyc++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        START = 1'b1; FUNCT3 = 3'b101; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
        got_lat = -1;
        for (int cyc = 1; cyc <= 60 && got_lat < 0; cyc++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
            if (done_w[0]) got_lat = cyc;
        end
        chk("b2b_lat", got_lat, 34);
        chk("b2b_res", res_w[0], 32'd14);

        wait_idle();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge CLK);
            #1;
            START     = ($urandom_range(3) == 0);
            FLUSH     = ($urandom_range(39) == 0);
            FUNCT3    = 3'($urandom_range(7));
            OPERAND_A = rnd_opnd();
            OPERAND_B = rnd_opnd();
        end
        START = 1'b0;
        FLUSH = 1'b0;
        wait_idle();
        @(posedge CLK);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
